// File: rtl/vec_cache_bank_rw_sched.sv
// Per-bank read/write request scheduler: weighted round-robin between the read
// and write xbars, one-deep output register per bank, and outstanding-request credits.
module vec_cache_bank_rw_sched #(
    parameter int BANK_NUM   = 4,
    parameter int RD_WEIGHT  = 3,
    parameter int WR_WEIGHT  = 1,
    parameter int CREDIT_NUM = 8,
    parameter int PLD_W      = 64,
    parameter int CREDIT_W   = $clog2(CREDIT_NUM + 1)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [BANK_NUM-1:0]                rd_vld,
    input  logic [BANK_NUM-1:0][PLD_W-1:0]     rd_pld,
    output logic [BANK_NUM-1:0]                rd_rdy,
    input  logic [BANK_NUM-1:0]                wr_vld,
    input  logic [BANK_NUM-1:0][PLD_W-1:0]     wr_pld,
    output logic [BANK_NUM-1:0]                wr_rdy,
    output logic [BANK_NUM-1:0]                bank_vld,
    output logic [BANK_NUM-1:0][PLD_W-1:0]     bank_pld,
    input  logic [BANK_NUM-1:0]                bank_rdy,
    input  logic [BANK_NUM-1:0]                credit_ret,
    output logic [BANK_NUM-1:0][CREDIT_W-1:0]  credit_cnt,
    output logic [BANK_NUM-1:0]                credit_err
);

    localparam int MAX_W = (RD_WEIGHT > WR_WEIGHT) ? RD_WEIGHT : WR_WEIGHT;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam logic [CNT_W-1:0]    RD_W_C = CNT_W'(RD_WEIGHT);
    localparam logic [CNT_W-1:0]    WR_W_C = CNT_W'(WR_WEIGHT);
    localparam logic [CNT_W-1:0]    ONE_C  = CNT_W'(1);
    localparam logic [CREDIT_W-1:0] FULL_C = CREDIT_W'(CREDIT_NUM);

    typedef enum logic {
        RD_PH,
        WR_PH
    } phase_t;

    for (genvar b = 0; b < BANK_NUM; b++) begin : g_slice
        phase_t               phase;
        logic [CNT_W-1:0]     grant_cnt;
        logic [CNT_W-1:0]     rd_cnt_inc;
        logic [CNT_W-1:0]     wr_cnt_inc;
        logic [CREDIT_W-1:0]  credit;
        logic                 err;
        logic                 out_vld;
        logic [PLD_W-1:0]     out_pld;
        logic                 can_grant;
        logic                 gnt_rd;
        logic                 gnt_wr;
        logic                 gnt;

        // Reset gating keeps the handshakes quiet while rst_n is low.
        always_comb begin
            can_grant = rst_n && (credit != '0) && (!out_vld || bank_rdy[b]);
            gnt_rd    = 1'b0;
            gnt_wr    = 1'b0;
            if (can_grant) begin
                if (phase == RD_PH) begin
                    if (rd_vld[b])      gnt_rd = 1'b1;
                    else if (wr_vld[b]) gnt_wr = 1'b1;
                end else begin
                    if (wr_vld[b])      gnt_wr = 1'b1;
                    else if (rd_vld[b]) gnt_rd = 1'b1;
                end
            end
            gnt        = gnt_rd | gnt_wr;
            rd_cnt_inc = (grant_cnt >= RD_W_C) ? RD_W_C : grant_cnt + ONE_C;
            wr_cnt_inc = (grant_cnt >= WR_W_C) ? WR_W_C : grant_cnt + ONE_C;
        end

        // Phase/weight: switch only once the weight is used up and the other side waits.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                phase     <= RD_PH;
                grant_cnt <= '0;
            end else if (gnt_rd) begin
                if (phase == RD_PH) begin
                    if (rd_cnt_inc == RD_W_C && wr_vld[b]) begin
                        phase     <= WR_PH;
                        grant_cnt <= '0;
                    end else begin
                        grant_cnt <= rd_cnt_inc;
                    end
                end else begin
                    phase     <= RD_PH;
                    grant_cnt <= ONE_C;
                end
            end else if (gnt_wr) begin
                if (phase == WR_PH) begin
                    if (wr_cnt_inc == WR_W_C && rd_vld[b]) begin
                        phase     <= RD_PH;
                        grant_cnt <= '0;
                    end else begin
                        grant_cnt <= wr_cnt_inc;
                    end
                end else begin
                    phase     <= WR_PH;
                    grant_cnt <= ONE_C;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                credit <= FULL_C;
                err    <= 1'b0;
            end else if (gnt && !credit_ret[b]) begin
                credit <= credit - 1'b1;
            end else if (!gnt && credit_ret[b]) begin
                if (credit == FULL_C) err    <= 1'b1;
                else                  credit <= credit + 1'b1;
            end
        end

        // Payload only loads on a grant, so it holds while stalled.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_vld <= 1'b0;
                out_pld <= '0;
            end else if (gnt) begin
                out_vld <= 1'b1;
                out_pld <= gnt_wr ? wr_pld[b] : rd_pld[b];
            end else if (bank_rdy[b]) begin
                out_vld <= 1'b0;
            end
        end

        assign rd_rdy[b]     = gnt_rd;
        assign wr_rdy[b]     = gnt_wr;
        assign bank_vld[b]   = out_vld;
        assign bank_pld[b]   = out_pld;
        assign credit_cnt[b] = credit;
        assign credit_err[b] = err;
    end

endmodule

// File: tb/tb_vec_cache_bank_rw_sched.sv
// Scoreboard bench for vec_cache_bank_rw_sched: expected payloads are queued at
// grant time and compared when the bank pipeline accepts them.
module tb_vec_cache_bank_rw_sched;

    localparam int BN = 4;
    localparam int PW = 64;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [BN-1:0]          rd_vld, wr_vld, rd_rdy, wr_rdy;
    logic [BN-1:0]          bank_vld, bank_rdy, credit_ret, credit_err;
    logic [BN-1:0][PW-1:0]  rd_pld, wr_pld, bank_pld;
    logic [BN-1:0][CW-1:0]  credit_cnt;

    int checks = 0;
    int errors = 0;
    logic [PW-1:0] exp_q[$];
    logic [31:0]   tag = 32'd0;

    vec_cache_bank_rw_sched #(
        .BANK_NUM(BN), .RD_WEIGHT(3), .WR_WEIGHT(1), .CREDIT_NUM(8), .PLD_W(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_vld(rd_vld), .rd_pld(rd_pld), .rd_rdy(rd_rdy),
        .wr_vld(wr_vld), .wr_pld(wr_pld), .wr_rdy(wr_rdy),
        .bank_vld(bank_vld), .bank_pld(bank_pld), .bank_rdy(bank_rdy),
        .credit_ret(credit_ret), .credit_cnt(credit_cnt), .credit_err(credit_err)
    );

    task automatic drive(input int b, input logic rv, input logic wv,
                         input logic br, input logic cr);
        tag           = tag + 32'd1;
        rd_vld[b]     = rv;
        wr_vld[b]     = wv;
        bank_rdy[b]   = br;
        credit_ret[b] = cr;
        rd_pld[b]     = {2'(b), 1'b0, 29'h0, tag};
        wr_pld[b]     = {2'(b), 1'b1, 29'h0, tag};
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rd_vld = '0; wr_vld = '0; bank_rdy = '0; credit_ret = '0;
        rd_pld = '0; wr_pld = '0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rd_vld = '1; wr_vld = '1; bank_rdy = '1; credit_ret = '0;
        rd_pld = '0; wr_pld = '0;
        @(negedge clk); #1;
        checks++;
        if ({rd_rdy, wr_rdy} !== 8'h00) begin
            errors++; $display("FAIL reset_rdy got %h exp 00", {rd_rdy, wr_rdy});
        end
        checks++;
        if (bank_vld !== 4'h0) begin
            errors++; $display("FAIL reset_bank_vld got %b exp 0000", bank_vld);
        end
        checks++;
        if (credit_cnt !== {4{4'd8}}) begin
            errors++; $display("FAIL reset_credit got %h exp 8888", credit_cnt);
        end
        checks++;
        if (credit_err !== 4'h0) begin
            errors++; $display("FAIL reset_credit_err got %b exp 0000", credit_err);
        end
    endtask

    task automatic test_weighted();
        logic prev_g, exp_w;
        logic [PW-1:0] e;
        apply_reset();
        prev_g = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_w = (i % 4 == 3);
            @(negedge clk); drive(0, 1'b1, 1'b1, 1'b1, prev_g); #1;
            checks++;
            if (bank_vld[0] !== prev_g) begin
                errors++; $display("FAIL wrr_bank_vld cyc %0d got %b exp %b", i, bank_vld[0], prev_g);
            end
            if (bank_vld[0]) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                checks++;
                if (bank_pld[0] !== e) begin
                    errors++; $display("FAIL wrr_pld cyc %0d got %h exp %h", i, bank_pld[0], e);
                end
            end
            checks++;
            if ({rd_rdy[0], wr_rdy[0]} !== {!exp_w, exp_w}) begin
                errors++; $display("FAIL wrr_grant cyc %0d got rd%b wr%b exp rd%b wr%b",
                                   i, rd_rdy[0], wr_rdy[0], !exp_w, exp_w);
            end
            if (i > 0) begin
                checks++;
                if (credit_cnt[0] !== 4'd7) begin
                    errors++; $display("FAIL wrr_credit cyc %0d got %0d exp 7", i, credit_cnt[0]);
                end
            end
            exp_q.push_back(exp_w ? wr_pld[0] : rd_pld[0]);
            prev_g = 1'b1;
        end
        @(negedge clk); drive(0, 1'b0, 1'b0, 1'b1, 1'b1); #1;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        checks++;
        if (bank_vld[0] !== 1'b1 || bank_pld[0] !== e) begin
            errors++; $display("FAIL wrr_last got vld %b pld %h exp vld 1 pld %h", bank_vld[0], bank_pld[0], e);
        end
        @(negedge clk); drive(0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
        checks++;
        if (bank_vld[0] !== 1'b0 || credit_cnt[0] !== 4'd8) begin
            errors++; $display("FAIL wrr_drain got vld %b credit %0d exp vld 0 credit 8", bank_vld[0], credit_cnt[0]);
        end
    endtask

    task automatic test_credit_exhaust();
        logic prev_g, exp_g;
        logic [PW-1:0] e;
        apply_reset();
        prev_g = 1'b0;
        for (int i = 0; i < 12; i++) begin
            exp_g = (i < 8);
            @(negedge clk); drive(2, 1'b1, 1'b0, 1'b1, 1'b0); #1;
            checks++;
            if (bank_vld[2] !== prev_g) begin
                errors++; $display("FAIL exh_bank_vld cyc %0d got %b exp %b", i, bank_vld[2], prev_g);
            end
            if (bank_vld[2]) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                checks++;
                if (bank_pld[2] !== e) begin
                    errors++; $display("FAIL exh_pld cyc %0d got %h exp %h", i, bank_pld[2], e);
                end
            end
            checks++;
            if (rd_rdy[2] !== exp_g) begin
                errors++; $display("FAIL exh_rd_rdy cyc %0d got %b exp %b", i, rd_rdy[2], exp_g);
            end
            checks++;
            if (credit_cnt[2] !== 4'((i < 8) ? 8 - i : 0)) begin
                errors++; $display("FAIL exh_credit cyc %0d got %0d exp %0d", i, credit_cnt[2], (i < 8) ? 8 - i : 0);
            end
            if (exp_g) exp_q.push_back(rd_pld[2]);
            prev_g = exp_g;
        end
        repeat (8) begin
            @(negedge clk); drive(2, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        @(negedge clk); drive(2, 1'b0, 1'b0, 1'b1, 1'b0); #1;
        checks++;
        if (credit_cnt[2] !== 4'd8 || credit_err[2] !== 1'b0) begin
            errors++; $display("FAIL exh_refill got credit %0d err %b exp 8 0", credit_cnt[2], credit_err[2]);
        end
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] first, second;
        apply_reset();
        @(negedge clk); drive(1, 1'b1, 1'b0, 1'b0, 1'b0); #1;
        first = rd_pld[1];
        checks++;
        if (rd_rdy[1] !== 1'b1) begin
            errors++; $display("FAIL bp_first_grant got %b exp 1", rd_rdy[1]);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); drive(1, 1'b1, 1'b0, 1'b0, 1'b0); #1;
            checks++;
            if (bank_vld[1] !== 1'b1 || bank_pld[1] !== first || rd_rdy[1] !== 1'b0) begin
                errors++; $display("FAIL bp_stall cyc %0d got vld %b pld %h rdy %b exp 1 %h 0",
                                   i, bank_vld[1], bank_pld[1], rd_rdy[1], first);
            end
        end
        @(negedge clk); drive(1, 1'b1, 1'b0, 1'b1, 1'b0); #1;
        second = rd_pld[1];
        checks++;
        if (rd_rdy[1] !== 1'b1) begin
            errors++; $display("FAIL bp_release_grant got %b exp 1", rd_rdy[1]);
        end
        @(negedge clk); drive(1, 1'b0, 1'b0, 1'b1, 1'b0); #1;
        checks++;
        if (bank_vld[1] !== 1'b1 || bank_pld[1] !== second || credit_cnt[1] !== 4'd6) begin
            errors++; $display("FAIL bp_next got vld %b pld %h credit %0d exp 1 %h 6",
                               bank_vld[1], bank_pld[1], credit_cnt[1], second);
        end
        @(negedge clk); drive(1, 1'b0, 1'b0, 1'b1, 1'b0); #1;
        checks++;
        if (bank_vld[1] !== 1'b0) begin
            errors++; $display("FAIL bp_drain got vld %b exp 0", bank_vld[1]);
        end
    endtask

    task automatic test_credit_err();
        apply_reset();
        @(negedge clk); drive(0, 1'b1, 1'b0, 1'b1, 1'b1); #1;
        checks++;
        if (rd_rdy[0] !== 1'b1) begin
            errors++; $display("FAIL cerr_grant_ret got %b exp 1", rd_rdy[0]);
        end
        @(negedge clk); drive(0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
        checks++;
        if (credit_cnt[0] !== 4'd8 || credit_err[0] !== 1'b0 || bank_vld[0] !== 1'b1) begin
            errors++; $display("FAIL cerr_same_cycle got credit %0d err %b vld %b exp 8 0 1",
                               credit_cnt[0], credit_err[0], bank_vld[0]);
        end
        @(negedge clk); drive(3, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk); drive(3, 1'b0, 1'b0, 1'b1, 1'b0); #1;
        checks++;
        if (credit_cnt[3] !== 4'd8 || credit_err !== 4'b1000) begin
            errors++; $display("FAIL cerr_overflow got credit %0d err %b exp 8 1000", credit_cnt[3], credit_err);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (credit_err !== 4'b1000) begin
            errors++; $display("FAIL cerr_sticky got %b exp 1000", credit_err);
        end
    endtask

    task automatic test_phase_switch();
        logic [7:0] wv_tab, expw_tab;
        logic prev_g, exp_w;
        logic [PW-1:0] e;
        wv_tab   = 8'b1111_0111;
        expw_tab = 8'b0100_0000;
        apply_reset();
        prev_g = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_w = expw_tab[i];
            @(negedge clk); drive(0, 1'b1, wv_tab[i], 1'b1, 1'b0); #1;
            if (bank_vld[0]) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                checks++;
                if (bank_pld[0] !== e) begin
                    errors++; $display("FAIL ph_pld cyc %0d got %h exp %h", i, bank_pld[0], e);
                end
            end else if (prev_g) begin
                checks++; errors++;
                $display("FAIL ph_bank_vld cyc %0d got 0 exp 1", i);
            end
            checks++;
            if ({rd_rdy[0], wr_rdy[0]} !== {!exp_w, exp_w}) begin
                errors++; $display("FAIL ph_grant cyc %0d got rd%b wr%b exp rd%b wr%b",
                                   i, rd_rdy[0], wr_rdy[0], !exp_w, exp_w);
            end
            exp_q.push_back(exp_w ? wr_pld[0] : rd_pld[0]);
            prev_g = 1'b1;
        end
        @(negedge clk); drive(0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        checks++;
        if (bank_vld[0] !== 1'b1 || bank_pld[0] !== e || credit_cnt[0] !== 4'd0) begin
            errors++; $display("FAIL ph_last got vld %b pld %h credit %0d exp 1 %h 0",
                               bank_vld[0], bank_pld[0], credit_cnt[0], e);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        repeat (3) begin
            @(negedge clk); drive(0, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        @(negedge clk); drive(0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
        checks++;
        if (bank_vld[0] !== 1'b1 || credit_cnt[0] !== 4'd5) begin
            errors++; $display("FAIL rst_mid_pre got vld %b credit %0d exp 1 5", bank_vld[0], credit_cnt[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bank_vld[0] !== 1'b0 || credit_cnt[0] !== 4'd8 || rd_rdy[0] !== 1'b0) begin
            errors++; $display("FAIL rst_mid_async got vld %b credit %0d rdy %b exp 0 8 0",
                               bank_vld[0], credit_cnt[0], rd_rdy[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b1, 1'b1, 1'b1, 1'b0); #1;
        checks++;
        if ({rd_rdy[0], wr_rdy[0]} !== 2'b10) begin
            errors++; $display("FAIL rst_mid_first got rd%b wr%b exp rd1 wr0", rd_rdy[0], wr_rdy[0]);
        end
        @(negedge clk); drive(0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_weighted();
        test_credit_exhaust();
        test_backpressure();
        test_credit_err();
        test_phase_switch();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_cache_bank_rw_sched.md
VEC_CACHE_BANK_RW_SCHED -- requirements
Module: vec_cache_bank_rw_sched

Interface
REQ-001 SHALL have parameter BANK_NUM, default 4, number of cache banks (one per addr[63:62] value).
REQ-002 SHALL have parameter RD_WEIGHT, default 3, max consecutive read grants per bank before yielding to a pending write.
REQ-003 SHALL have parameter WR_WEIGHT, default 1, max consecutive write grants per bank before yielding to a pending read.
REQ-004 SHALL have parameter CREDIT_NUM, default 8, outstanding-request credits per bank; CREDIT_W = $clog2(CREDIT_NUM+1).
REQ-005 SHALL have port clk, input, 1, single clock.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port rd_vld, input, BANK_NUM, read request valid per bank from the read request xbar.
REQ-008 SHALL have port rd_pld, input, input_req_pld_t [BANK_NUM], read request payload per bank.
REQ-009 SHALL have port rd_rdy, output, BANK_NUM, read request accepted this cycle.
REQ-010 SHALL have port wr_vld, input, BANK_NUM, write request valid per bank from the write request xbar.
REQ-011 SHALL have port wr_pld, input, input_req_pld_t [BANK_NUM], write request payload per bank.
REQ-012 SHALL have port wr_rdy, output, BANK_NUM, write request accepted this cycle.
REQ-013 SHALL have port bank_vld, output, BANK_NUM, scheduled request valid to bank pipeline.
REQ-014 SHALL have port bank_pld, output, input_req_pld_t [BANK_NUM], scheduled request payload.
REQ-015 SHALL have port bank_rdy, input, BANK_NUM, bank pipeline accepts request.
REQ-016 SHALL have port credit_ret, input, BANK_NUM, one credit returned to bank b per cycle asserted.
REQ-017 SHALL have port credit_cnt, output, CREDIT_W [BANK_NUM], current available credits per bank.
REQ-018 SHALL have port credit_err, output, BANK_NUM, sticky flag: credit returned while counter already at CREDIT_NUM.

Function
REQ-019 SHALL instantiate BANK_NUM independent scheduler slices; no cross-bank interaction.
REQ-020 Each slice SHALL hold one output register (bank_vld/bank_pld); bank_pld SHALL be stable while bank_vld=1 and bank_rdy=0.
REQ-021 Slice SHALL be able to grant when credit_cnt!=0 and (output register empty or bank_rdy=1 this cycle); otherwise rd_rdy=wr_rdy=0.
REQ-022 At most one of rd_rdy[b], wr_rdy[b] SHALL be 1 per cycle; rd_rdy/wr_rdy SHALL be combinational from vld, phase, weight counter, credit, output-register state.
REQ-023 Granted payload SHALL appear on bank_pld with bank_vld=1 the next cycle (latency 1); back-to-back grants SHALL sustain 1 request/cycle while bank_rdy=1.
REQ-024 Phase FSM per slice, states RD_PH, WR_PH, counter grant_cnt.
REQ-025 In RD_PH: if rd_vld grant read, grant_cnt++; when grant_cnt reaches RD_WEIGHT and wr_vld=1, move to WR_PH, grant_cnt=0.
REQ-026 In WR_PH: symmetric with wr_vld, WR_WEIGHT, returning to RD_PH.
REQ-027 If current-phase side not valid and other side valid, SHALL grant other side, switch phase, set grant_cnt=1.
REQ-028 When weight reached but other side not valid, SHALL keep granting current side and hold grant_cnt saturated at weight.
REQ-029 No grant cycle (neither valid or no credit) SHALL leave phase and grant_cnt unchanged.
REQ-030 credit_cnt SHALL decrement by 1 on each grant, increment by 1 on credit_ret; both same cycle: unchanged.
REQ-031 credit_ret at credit_cnt=CREDIT_NUM without same-cycle grant SHALL leave counter unchanged and set credit_err[b] until reset.
REQ-032 credit_cnt SHALL never underflow; grant blocked at 0 per REQ-021.

Reset
REQ-033 On rst_n=0 (asynchronous), any cycle: bank_vld=0, credit_cnt=CREDIT_NUM, credit_err=0, phase=RD_PH, grant_cnt=0; in-flight output-register content discarded.
REQ-034 bank_pld SHALL be don't-care while bank_vld=0; rd_rdy/wr_rdy SHALL be 0 during reset.

Verification
REQ-035 Bank0 rd_vld and wr_vld held 1, bank_rdy=1, credit_ret tied to 1-cycle-delayed handshake -> grant sequence R,R,R,W,R,R,R,W...
REQ-036 Only rd_vld[2]=1 for 12 cycles, bank_rdy=1, no credit_ret -> 8 grants, credit_cnt[2]=0, rd_rdy[2]=0 thereafter, bank_vld drops after 9th cycle.
REQ-037 bank_vld[1]=1, bank_rdy[1]=0 for 5 cycles -> bank_pld[1] stable, no grants; bank_rdy=1 -> new grant accepted same cycle, next payload at next edge.
REQ-038 credit_ret[3]=1 with credit_cnt[3]=8 -> credit_cnt stays 8, credit_err[3]=1 and sticky; same-cycle grant+return -> count unchanged, no error.
REQ-039 In WR_PH wr_vld drops, rd_vld=1 -> read granted immediately, phase=RD_PH, grant_cnt=1.
REQ-040 rst_n asserted mid-burst with bank_vld=1, credit_cnt=5 -> bank_vld=0, credit_cnt=8 immediately, first grant after release is read.
